frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Consumes the one-cycle `slow_clock` tick from the rate divider and turns it into an ordered per-frame handshake sequence: first a game-logic update request, then a render request. It sits directly downstream of the rate divider and upstream of the game-state and raycast renderer blocks. It buffers one early tick, counts completed frames, and counts ticks dropped because the pipeline was still busy.

## Interface
Parameters:
- `FRAME_W`, 16: width of the completed-frame counter.
- `OVR_W`, 8: width of the saturating overrun counter.
- `WDT_CYCLES`, 50_000_000: watchdog limit in clock cycles. Used only when the watchdog is compiled in.

Ports:
- `CLOCK_50`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle pulse from the rate divider, same clock domain.
- `enable`  in  1  0 = paused; new frames are not started.
- `update_req`  out  1  level request to game logic.
- `update_done`  in  1  one-cycle completion pulse from game logic.
- `render_req`  out  1  level request to the renderer.
- `render_done`  in  1  one-cycle completion pulse from the renderer.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_count`  out  FRAME_W  number of completed frames; wraps.
- `overrun_count`  out  OVR_W  number of dropped ticks; saturates at all-ones.
- `timeout`  out  1  one-cycle pulse on a watchdog abort.

## Operation
- States are IDLE, UPDATE and RENDER.
- IDLE → UPDATE when `enable` = 1 and (`tick` or `pending`). Entering UPDATE clears `pending`.
- UPDATE → RENDER on `update_done`.
- RENDER → IDLE on `render_done`. This transition increments `frame_count`, which wraps modulo 2^FRAME_W.
- `update_req` is high exactly while in UPDATE; `render_req` is high exactly while in RENDER. Both are registered state decodes.
- Tick while not IDLE:
  - if `pending` = 0, set `pending`;
  - otherwise increment `overrun_count` (saturating).
- Tick in IDLE with `enable` = 0 is discarded. It is not counted and does not set `pending`.
- `pending` that is already set survives a pause and is consumed once `enable` returns to 1.
- `update_done` outside UPDATE and `render_done` outside RENDER are ignored.
- Simultaneous events:
  - `tick` in the same cycle as the RENDER→IDLE transition sets `pending`; the next frame starts one cycle later.
  - `tick` in the same cycle as the UPDATE→RENDER transition is treated as not-IDLE.
- `enable` falling mid-frame does not abort the frame; the current frame completes.

## Timing
- Reset values: state = IDLE, `pending` = 0, `update_req` = 0, `render_req` = 0, `busy` = 0, `frame_count` = 0, `overrun_count` = 0, `timeout` = 0, watchdog counter = 0.
- Latency from `tick` at cycle N (IDLE, enabled) to `update_req` = 1 at cycle N+1.
- Latency from `update_done` at cycle M to `update_req` = 0 and `render_req` = 1 at M+1.
- `render_done` at cycle K gives `render_req` = 0, `busy` = 0 and the incremented `frame_count` at K+1.
- The minimum frame is 3 cycles (done pulses arriving on the first request cycle).
- Fast-rate case: with the divider's fastest select (a tick every 2 cycles), a sustained overrun is expected and `overrun_count` saturates.
- Reset mid-frame: all registers return to reset values on the next edge, and the requests drop immediately on that edge.

## Configuration
- `FRAME_SCHED_WATCHDOG_EN` defined:
  - A 32-bit counter runs in UPDATE and RENDER and is cleared on every state change.
  - When it reaches `WDT_CYCLES` − 1, the FSM returns to IDLE and `timeout` pulses for 1 cycle.
  - `frame_count` is not incremented on a timeout, and `pending` is kept.
- `FRAME_SCHED_WATCHDOG_EN` not defined:
  - No counter is built and `timeout` is tied to 0.
  - The FSM waits indefinitely for the done pulses.

## Structure
- Package `frame_sched_pkg` holds:
  - the state enum (IDLE=2'd0, UPDATE=2'd1, RENDER=2'd2);
  - the default values of `FRAME_W`, `OVR_W` and `WDT_CYCLES`.
- Sub-module `sat_counter`, parameterised by width, with synchronous clear and increment enable. It is instantiated for `overrun_count`.
- All other logic (FSM, `pending` latch, frame counter, watchdog) stays in `frame_scheduler`.

## Test plan
- Basic frame: reset, `enable` = 1, one tick, then `update_done` 3 cycles later and `render_done` 5 cycles after that. Check `update_req` high for 4 cycles, `render_req` high for 6 cycles, `frame_count` = 1, `overrun_count` = 0.
- Buffered tick and overrun: 3 ticks during a single frame. Check `pending` gives one back-to-back frame starting the cycle after `render_done`, and `overrun_count` = 1.
- Pause: `enable` = 0 with 5 ticks in IDLE, so no request and counters unchanged. Then one tick mid-frame followed by `enable` = 0 at `render_done`. Check the next frame starts only when `enable` returns to 1.
- Saturation and wrap:
  - hold a frame open across 300 ticks and check `overrun_count` = 255 (OVR_W = 8);
  - preload by running 65536 frames and check `frame_count` wraps to 0.
- Reset mid-RENDER: check all outputs are 0 on the next cycle, and a `render_done` one cycle later is ignored.
- Watchdog (macro defined, WDT_CYCLES = 20): never send `update_done`. Check `timeout` pulses at cycle 20 of UPDATE, state returns to IDLE, and `frame_count` is unchanged.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and default sizes for the per-frame scheduler.
// Imported by frame_scheduler and sat_counter.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    RENDER = 2'd2
  } state_t;

  localparam int FRAME_W_DEF    = 16;
  localparam int OVR_W_DEF      = 8;
  localparam int WDT_CYCLES_DEF = 50_000_000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear and reset.
// Used for the dropped-tick count.
module sat_counter
  import frame_sched_pkg::*;
#(
  parameter int W = OVR_W_DEF
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Turns rate-divider ticks into an update-then-render handshake per frame.
// Optional watchdog abort: define FRAME_SCHED_WATCHDOG_EN.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int OVR_W      = OVR_W_DEF,
  parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               tick,
  input  logic               enable,
  output logic               update_req,
  input  logic               update_done,
  output logic               render_req,
  input  logic               render_done,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_count,
  output logic [OVR_W-1:0]   overrun_count,
  output logic               timeout
);

  state_t state;
  logic   pending;
  logic   start;
  logic   upd_fin;
  logic   rnd_fin;
  logic   ovr_inc;
  logic   wdt_hit;

  assign start   = (state == IDLE) && enable
                && (tick || pending);
  assign upd_fin = (state == UPDATE) && update_done;
  assign rnd_fin = (state == RENDER) && render_done;
  // Only a second tick while one is already buffered is lost.
  assign ovr_inc = tick && (state != IDLE) && pending;

`ifdef FRAME_SCHED_WATCHDOG_EN
  localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);

  logic [31:0] wdt_cnt;

  assign wdt_hit = (state != IDLE) && !upd_fin
                && !rnd_fin && (wdt_cnt == WDT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if ((state == IDLE) || upd_fin
                 || rnd_fin || wdt_hit) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 32'd1;
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      update_req  <= 1'b0;
      render_req  <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (tick && (state != IDLE) && !pending) begin
        pending <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= UPDATE;
            pending    <= 1'b0;
            update_req <= 1'b1;
            busy       <= 1'b1;
          end
        end
        UPDATE: begin
          if (upd_fin) begin
            state      <= RENDER;
            update_req <= 1'b0;
            render_req <= 1'b1;
          end else if (wdt_hit) begin
            state      <= IDLE;
            update_req <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b1;
          end
        end
        RENDER: begin
          if (rnd_fin) begin
            state       <= IDLE;
            render_req  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= frame_count + FRAME_W'(1);
          end else if (wdt_hit) begin
            state      <= IDLE;
            render_req <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          update_req <= 1'b0;
          render_req <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(OVR_W)
  ) u_ovr (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (1'b0),
    .inc     (ovr_inc),
    .count   (overrun_count)
  );

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench: expected outputs are queued per cycle by the
// stimulus and popped by an independent negedge monitor.
module tb_frame_scheduler;

  localparam int FW  = 8;
  localparam int OW  = 8;
  localparam int WDT = 20;

  localparam int S_U = 0;
  localparam int S_R = 1;
  localparam int S_B = 2;
  localparam int S_F = 3;
  localparam int S_O = 4;
  localparam int S_T = 5;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          enable = 1'b0;
  logic          update_done = 1'b0;
  logic          render_done = 1'b0;
  logic          update_req;
  logic          render_req;
  logic          busy;
  logic          timeout;
  logic [FW-1:0] frame_count;
  logic [OW-1:0] overrun_count;

  frame_scheduler #(
    .FRAME_W   (FW),
    .OVR_W     (OW),
    .WDT_CYCLES(WDT)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .tick         (tick),
    .enable       (enable),
    .update_req   (update_req),
    .update_done  (update_done),
    .render_req   (render_req),
    .render_done  (render_done),
    .busy         (busy),
    .frame_count  (frame_count),
    .overrun_count(overrun_count),
    .timeout      (timeout)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  function automatic void expect_at(int dc, int sig,
                                    int val, string name);
    exp_t e;
    int   idx;
    e.at   = cyc + dc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    idx = sbq.size();
    while (idx > 0 && sbq[idx-1].at > e.at) idx--;
    sbq.insert(idx, e);
  endfunction

  function automatic void exp_st(int dc, int u, int r, int to);
    expect_at(dc, S_U, u, "update_req");
    expect_at(dc, S_R, r, "render_req");
    expect_at(dc, S_B, u | r, "busy");
    expect_at(dc, S_T, to, "timeout");
  endfunction

  function automatic void exp_u(int dc);
    exp_st(dc, 1, 0, 0);
  endfunction

  function automatic void exp_r(int dc);
    exp_st(dc, 0, 1, 0);
  endfunction

  function automatic void exp_idle(int dc, int fc, int oc);
    exp_st(dc, 0, 0, 0);
    expect_at(dc, S_F, fc, "frame_count");
    expect_at(dc, S_O, oc, "overrun_count");
  endfunction

  function automatic int get_sig(int s);
    case (s)
      S_U:     return int'(update_req);
      S_R:     return int'(render_req);
      S_B:     return int'(busy);
      S_F:     return int'(frame_count);
      S_O:     return int'(overrun_count);
      default: return int'(timeout);
    endcase
  endfunction

  exp_t me;
  int   act;
  always @(negedge CLOCK_50) begin
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      me  = sbq.pop_front();
      act = get_sig(me.sig);
      total++;
      if (me.at < cyc) begin
        bad++;
        $display("FAIL %s stale cyc=%0d now=%0d",
                 me.name, me.at, cyc);
      end else if (act != me.val) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%0d want=%0d",
                 me.name, cyc, act, me.val);
      end
    end
  end

  task automatic step(input logic t, input logic u,
                      input logic r);
    tick        = t;
    update_done = u;
    render_done = r;
    @(posedge CLOCK_50);
    #1;
    tick        = 1'b0;
    update_done = 1'b0;
    render_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    // reset, including a tick that must be ignored
    exp_idle(1, 0, 0);
    step(0, 0, 0);
    exp_idle(1, 0, 0);
    step(1, 0, 0);
    reset  = 1'b0;
    enable = 1'b1;

    // basic frame: 4 update cycles, 6 render cycles
    for (int k = 1; k <= 4; k++) exp_u(k);
    for (int k = 5; k <= 10; k++) exp_r(k);
    exp_idle(11, 1, 0);
    step(1, 0, 0);
    idle(3);
    step(0, 1, 0);
    idle(5);
    step(0, 0, 1);
    idle(1);

    // buffered tick plus one overrun, back-to-back frame
    exp_u(1);
    exp_u(2);
    exp_r(3);
    expect_at(3, S_O, 1, "overrun_count");
    exp_r(4);
    exp_idle(5, 2, 1);
    exp_u(6);
    exp_r(7);
    exp_idle(8, 3, 1);
    exp_idle(9, 3, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    idle(2);

    // paused ticks are discarded
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_idle(1, 3, 1);
      step(1, 0, 0);
    end
    enable = 1'b1;

    // pending survives a pause at render_done
    exp_u(1);
    exp_u(2);
    exp_r(3);
    exp_r(4);
    for (int k = 5; k <= 8; k++) exp_idle(k, 4, 1);
    exp_u(9);
    exp_r(10);
    exp_idle(11, 5, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    enable = 1'b0;
    step(0, 0, 1);
    idle(3);
    enable = 1'b1;
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    idle(1);

    // 300 ticks every 2 cycles inside one frame saturate at 255
    exp_u(1);
    step(1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      exp_u(1);
      expect_at(1, S_O, (1 + i > 255) ? 255 : 1 + i,
                "overrun_sat");
      step(1, 0, 0);
      exp_u(1);
      step(0, 0, 0);
    end
    exp_r(1);
    step(0, 1, 0);
    exp_idle(1, 6, 255);
    step(0, 0, 1);
    exp_u(1);
    step(0, 0, 0);
    exp_r(1);
    step(0, 1, 0);
    exp_idle(1, 7, 255);
    step(0, 0, 1);

    // minimum 3-cycle frames until frame_count wraps
    for (int n = 1; n <= 249; n++) begin
      exp_u(1);
      step(1, 0, 0);
      exp_r(1);
      step(0, 1, 0);
      exp_idle(1, (7 + n) % 256, 255);
      step(0, 0, 1);
    end

    // reset in RENDER; a late render_done is ignored
    exp_u(1);
    step(1, 0, 0);
    exp_r(1);
    step(0, 1, 0);
    reset = 1'b1;
    exp_idle(1, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
    exp_idle(1, 0, 0);
    step(0, 0, 1);
    exp_idle(1, 0, 0);
    step(0, 0, 0);
    exp_u(1);
    step(1, 0, 0);
    exp_r(1);
    step(0, 1, 0);
    exp_idle(1, 1, 0);
    step(0, 0, 1);

`ifdef FRAME_SCHED_WATCHDOG_EN
    // abort after WDT cycles of UPDATE; buffered tick restarts
    for (int k = 1; k <= WDT; k++) exp_u(k);
    exp_st(WDT + 1, 0, 0, 1);
    expect_at(WDT + 1, S_F, 1, "frame_count_wdt");
    exp_u(WDT + 2);
    step(1, 0, 0);
    idle(4);
    step(1, 0, 0);
    idle(16);
    exp_r(1);
    step(0, 1, 0);
    exp_idle(1, 2, 0);
    step(0, 0, 1);
`endif

    idle(2);
    for (int i = 0; i < 100 && sbq.size() > 0; i++) idle(1);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain left=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
